// File: rtl/change_log_arbiter_if.sv
// Request and memory-port bundle between the change loggers, the shared log
// memory and the control thread.
interface change_log_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_LEN   = 10
) ();
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic                          CLEAR;
    logic [ADDR_LEN-1:0]           MEM_ADDR;
    logic [DATA_WIDTH-1:0]         MEM_D;
    logic                          MEM_WE;
    logic [4:0]                    GRANT_ID;
    logic [ADDR_LEN:0]             COUNT;
    logic                          FULL;

    modport master (
        output REQ_DATA, REQ_VALID, CLEAR,
        input  REQ_READY, MEM_ADDR, MEM_D, MEM_WE, GRANT_ID, COUNT, FULL
    );

    modport slave (
        input  REQ_DATA, REQ_VALID, CLEAR,
        output REQ_READY, MEM_ADDR, MEM_D, MEM_WE, GRANT_ID, COUNT, FULL
    );
endinterface

// File: rtl/change_log_arbiter.sv
// Round-robin arbiter sharing one single-port memory write port among the
// change loggers; one holding slot per requester, writes go to consecutive addresses.
module change_log_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_LEN   = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    change_log_arbiter_if.slave  bus
);
    localparam int unsigned ID_W  = 5;
    localparam int unsigned SUM_W = ID_W + 1;
    localparam int unsigned CNT_W = ADDR_LEN + 1;
    localparam logic [CNT_W-1:0] CAPACITY = {1'b1, {ADDR_LEN{1'b0}}};

    logic [NUM_REQ-1:0]    hold_valid;
    logic [DATA_WIDTH-1:0] hold_data [NUM_REQ];
    logic [ADDR_LEN-1:0]   wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic [ID_W-1:0]       rr_ptr;

    logic                  mem_we;
    logic [ADDR_LEN-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_d;
    logic [ID_W-1:0]       grant_id;

    logic [NUM_REQ-1:0]    rot_c;
    logic [ID_W-1:0]       off_c;
    logic [SUM_W-1:0]      sum_c;
    logic                  grant_valid_c;
    logic [ID_W-1:0]       grant_id_c;
    logic [DATA_WIDTH-1:0] grant_data_c;

    // Rotate the held slots so rr_ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot_c         = NUM_REQ'({hold_valid, hold_valid} >> rr_ptr);
        off_c         = '0;
        grant_valid_c = 1'b0;
        grant_data_c  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot_c[j]) begin
                off_c         = ID_W'(j);
                grant_valid_c = 1'b1;
            end
        end
        sum_c = SUM_W'(rr_ptr) + SUM_W'(off_c);
        if (sum_c >= SUM_W'(NUM_REQ)) begin
            grant_id_c = ID_W'(sum_c - SUM_W'(NUM_REQ));
        end else begin
            grant_id_c = ID_W'(sum_c);
        end
        if (full || bus.CLEAR) begin
            grant_valid_c = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_c == ID_W'(i)) begin
                grant_data_c = hold_data[i];
            end
        end
    end

    // Slot occupancy: a slot is either being filled or being drained, never both.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hold_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.REQ_VALID[i] && !hold_valid[i]) begin
                    hold_valid[i] <= 1'b1;
                end else if (grant_valid_c && grant_id_c == ID_W'(i)) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payload needs no reset; hold_valid qualifies it.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (RST && bus.REQ_VALID[i] && !hold_valid[i]) begin
                hold_data[i] <= bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Write port, log pointer, fill level and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            rr_ptr   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_d    <= '0;
            grant_id <= '0;
        end else if (bus.CLEAR) begin
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            mem_we <= 1'b0;
        end else if (grant_valid_c) begin
            mem_we   <= 1'b1;
            mem_addr <= wr_ptr;
            mem_d    <= grant_data_c;
            grant_id <= grant_id_c;
            wr_ptr   <= wr_ptr + ADDR_LEN'(1);
            count    <= count + CNT_W'(1);
            full     <= (count + CNT_W'(1)) == CAPACITY;
            rr_ptr   <= (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
        end else begin
            mem_we <= 1'b0;
        end
    end

    assign bus.REQ_READY = {NUM_REQ{RST}} & ~hold_valid;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_D     = mem_d;
    assign bus.GRANT_ID  = grant_id;
    assign bus.COUNT     = count;
    assign bus.FULL      = full;
endmodule

// File: tb/tb_change_log_arbiter.sv
// Bench for change_log_arbiter: a 1024-word and an 8-word instance share one
// stimulus stream and are checked against a per-instance reference model.
module tb_change_log_arbiter;
    localparam int unsigned NR   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned AL_A = 10;
    localparam int unsigned AL_B = 3;

    logic clk;
    logic rst;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_valid;
    logic             clear;

    int n_vec = 0;
    int n_err = 0;

    change_log_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_LEN(AL_A)) ifa ();
    change_log_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_LEN(AL_B)) ifb ();

    assign ifa.REQ_DATA  = req_data;
    assign ifa.REQ_VALID = req_valid;
    assign ifa.CLEAR     = clear;
    assign ifb.REQ_DATA  = req_data;
    assign ifb.REQ_VALID = req_valid;
    assign ifb.CLEAR     = clear;

    change_log_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_LEN(AL_A)) dut_a (
        .CLK(clk), .RST(rst), .bus(ifa.slave));
    change_log_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_LEN(AL_B)) dut_b (
        .CLK(clk), .RST(rst), .bus(ifb.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    bit          m_hold [2][NR];
    logic [31:0] m_data [2][NR];
    int          m_wr   [2];
    int          m_cnt  [2];
    int          m_rr   [2];
    bit          m_we   [2];
    int          m_addr [2];
    logic [31:0] m_d    [2];
    int          m_gid  [2];

    function automatic int cap_of(int k);
        return (k == 0) ? (1 << AL_A) : (1 << AL_B);
    endfunction

    task automatic model_step(int k);
        int  cap;
        bit  gv;
        int  g;
        int  c;
        cap = cap_of(k);
        gv  = 1'b0;
        g   = 0;
        if (!rst) begin
            for (int i = 0; i < NR; i++) m_hold[k][i] = 1'b0;
            m_wr[k] = 0; m_cnt[k] = 0; m_rr[k] = 0;
            m_we[k] = 1'b0; m_addr[k] = 0; m_d[k] = '0; m_gid[k] = 0;
        end else begin
            if (m_cnt[k] != cap && !clear) begin
                for (int j = 0; j < NR; j++) begin
                    c = (m_rr[k] + j) % NR;
                    if (!gv && m_hold[k][c]) begin
                        gv = 1'b1;
                        g  = c;
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && !m_hold[k][i]) begin
                    m_hold[k][i] = 1'b1;
                    m_data[k][i] = req_data[i*DW +: DW];
                end
            end
            if (clear) begin
                m_wr[k] = 0; m_cnt[k] = 0; m_we[k] = 1'b0;
            end else if (gv) begin
                m_we[k]   = 1'b1;
                m_addr[k] = m_wr[k];
                m_d[k]    = m_data[k][g];
                m_gid[k]  = g;
                m_hold[k][g] = 1'b0;
                m_wr[k]   = (m_wr[k] + 1) % cap;
                m_cnt[k]  = m_cnt[k] + 1;
                m_rr[k]   = (g + 1) % NR;
            end else begin
                m_we[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [63:0] m_ready(int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i] = rst && !m_hold[k][i];
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("a_ready", 64'(ifa.REQ_READY), m_ready(0));
        chk("a_we",    64'(ifa.MEM_WE),    64'(m_we[0]));
        chk("a_addr",  64'(ifa.MEM_ADDR),  64'(m_addr[0]));
        chk("a_d",     64'(ifa.MEM_D),     64'(m_d[0]));
        chk("a_gid",   64'(ifa.GRANT_ID),  64'(m_gid[0]));
        chk("a_count", 64'(ifa.COUNT),     64'(m_cnt[0]));
        chk("a_full",  64'(ifa.FULL),      64'(m_cnt[0] == cap_of(0)));
        chk("b_ready", 64'(ifb.REQ_READY), m_ready(1));
        chk("b_we",    64'(ifb.MEM_WE),    64'(m_we[1]));
        chk("b_addr",  64'(ifb.MEM_ADDR),  64'(m_addr[1]));
        chk("b_d",     64'(ifb.MEM_D),     64'(m_d[1]));
        chk("b_gid",   64'(ifb.GRANT_ID),  64'(m_gid[1]));
        chk("b_count", 64'(ifb.COUNT),     64'(m_cnt[1]));
        chk("b_full",  64'(ifb.FULL),      64'(m_cnt[1] == cap_of(1)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; req_valid = '0; req_data = '0;
        // Reset state
        idle(2);
        chk("rst_ready", 64'(ifa.REQ_READY), 64'h0);
        chk("rst_count", 64'(ifa.COUNT), 64'h0);

        // Single request on requester 2
        rst = 1'b1;
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 32'hAAAA0002;
        cycle();
        chk("t1_ready_held", 64'(ifa.REQ_READY), 64'hB);
        req_valid = '0;
        cycle();
        chk("t1_we",    64'(ifa.MEM_WE),    64'h1);
        chk("t1_addr",  64'(ifa.MEM_ADDR),  64'h0);
        chk("t1_d",     64'(ifa.MEM_D),     64'hAAAA0002);
        chk("t1_gid",   64'(ifa.GRANT_ID),  64'h2);
        chk("t1_count", 64'(ifa.COUNT),     64'h1);
        chk("t1_ready", 64'(ifa.REQ_READY), 64'hF);

        // All four at once after a fresh reset: order 0..3 at addresses 0..3
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h100 + 32'(i);
        cycle();
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            cycle();
            chk("t2_gid",  64'(ifa.GRANT_ID), 64'(i));
            chk("t2_addr", 64'(ifa.MEM_ADDR), 64'(i));
            chk("t2_d",    64'(ifa.MEM_D),    64'(32'h100 + 32'(i)));
        end
        chk("t2_count", 64'(ifa.COUNT), 64'h4);

        // Move rr_ptr to 2, then hold all four continuously for 12 grants
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
        cycle();
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
            cycle();
            chk("t3_we",  64'(ifa.MEM_WE),   64'h1);
            chk("t3_gid", 64'(ifa.GRANT_ID), 64'((2 + n) % 4));
        end
        req_valid = '0;

        // Small instance is full with every slot held
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("t4_full",  64'(ifb.FULL),      64'h1);
            chk("t4_count", 64'(ifb.COUNT),     64'h8);
            chk("t4_we",    64'(ifb.MEM_WE),    64'h0);
            chk("t4_ready", 64'(ifb.REQ_READY), 64'h0);
        end
        clear = 1'b1;
        cycle();
        chk("t4_clr_count", 64'(ifb.COUNT), 64'h0);
        chk("t4_clr_full",  64'(ifb.FULL),  64'h0);
        clear = 1'b0;
        cycle();
        chk("t4_post_we",   64'(ifb.MEM_WE),   64'h1);
        chk("t4_post_addr", 64'(ifb.MEM_ADDR), 64'h0);
        idle(6);

        // CLEAR against a pending grant
        req_valid = 4'b0001;
        req_data[0 +: DW] = 32'hC1EA0000;
        cycle();
        req_valid = '0;
        clear = 1'b1;
        cycle();
        chk("t5_we_blocked", 64'(ifa.MEM_WE), 64'h0);
        clear = 1'b0;
        cycle();
        chk("t5_we",   64'(ifa.MEM_WE),   64'h1);
        chk("t5_addr", 64'(ifa.MEM_ADDR), 64'h0);
        chk("t5_d",    64'(ifa.MEM_D),    64'hC1EA0000);

        // Reset with three words held
        req_valid = 4'b0111;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
        cycle();
        req_valid = '0;
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            cycle();
            chk("t6_ready", 64'(ifa.REQ_READY), 64'h0);
            chk("t6_we",    64'(ifa.MEM_WE),    64'h0);
            chk("t6_count", 64'(ifa.COUNT),     64'h0);
        end
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("t6_rel_ready", 64'(ifa.REQ_READY), 64'hF);
            chk("t6_rel_we",    64'(ifa.MEM_WE),    64'h0);
        end

        // Random traffic with occasional CLEAR and reset
        for (int n = 0; n < 400; n++) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
            clear = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
